// File: rtl/pixel_row_reader.sv
// Purpose: capture whole pixel rows off the column bus into a 2-entry ping-pong buffer, stream pixels out.
// Latency: NEW_ROW into an empty buffer shows its first pixel on OUT_* right after the capturing edge.
// Backpressure: OUT_READY low holds all OUT_* stable; rows arriving with both entries busy are dropped (sticky OVERRUN).
module pixel_row_reader #(
    parameter int PIXEL_ARRAY_WIDTH  = 2,
    parameter int PIXEL_ARRAY_HEIGHT = 2,
    parameter int PIXEL_BITS         = 8,
    localparam int ROW_W = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1,
    localparam int COL_W = (PIXEL_ARRAY_WIDTH > 1) ? $clog2(PIXEL_ARRAY_WIDTH) : 1,
    localparam int BUS_W = PIXEL_ARRAY_WIDTH * PIXEL_BITS
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  NEW_ROW,
    input  logic                  FRAME_FINISHED,
    input  logic [BUS_W-1:0]      ROW_DATA,
    output logic [PIXEL_BITS-1:0] OUT_DATA,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [ROW_W-1:0]      OUT_ROW,
    output logic [COL_W-1:0]      OUT_COL,
    output logic                  OUT_LAST,
    output logic                  OVERRUN
);

    // Streaming FSM: IDLE has nothing to present, STREAM drives a pixel onto OUT_*.
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(PIXEL_ARRAY_WIDTH - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(PIXEL_ARRAY_HEIGHT - 1);

    // Ping-pong row storage: full row of pixels plus the row index it was tagged with.
    logic [BUS_W-1:0]      buf_data_q [2];
    logic [BUS_W-1:0]      buf_data_d [2];
    logic [ROW_W-1:0]      buf_row_q  [2];
    logic [ROW_W-1:0]      buf_row_d  [2];

    logic [1:0]            occ_q, occ_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [ROW_W-1:0]      row_cnt_q, row_cnt_d;
    logic [0:0]            state_q, state_d;

    // Registered outputs; out_col_q doubles as the read column within entry[rd_ptr].
    logic [PIXEL_BITS-1:0] out_data_q, out_data_d;
    logic [ROW_W-1:0]      out_row_q, out_row_d;
    logic [COL_W-1:0]      out_col_q, out_col_d;
    logic                  out_last_q, out_last_d;
    logic                  overrun_q, overrun_d;

    logic                  xfer;
    logic                  free_rd;
    logic                  slot_free;
    logic                  do_wr;
    logic                  drop;
    logic [BUS_W-1:0]      sel_row;

    // Handshake decode: a transfer on the last column releases the read entry this cycle,
    // which lets a NEW_ROW landing on a full buffer reuse that entry immediately.
    always_comb begin
        xfer      = (state_q == ST_STREAM) && OUT_READY;
        free_rd   = xfer && (out_col_q == LAST_COL);
        slot_free = (occ_q != 2'd2) || free_rd;
        do_wr     = NEW_ROW && slot_free;
        drop      = NEW_ROW && !slot_free;
    end

    // Buffer write: the bus is sampled exactly once, into the entry wr_ptr points at.
    always_comb begin
        for (int e = 0; e < 2; e++) begin
            buf_data_d[e] = buf_data_q[e];
            buf_row_d[e]  = buf_row_q[e];
        end
        if (do_wr) begin
            buf_data_d[wr_ptr_q] = ROW_DATA;
            buf_row_d[wr_ptr_q]  = row_cnt_q;
        end
    end

    // Occupancy and pointers: read release and write fill may happen in the same cycle.
    always_comb begin
        occ_d    = occ_q - {1'b0, free_rd} + {1'b0, do_wr};
        wr_ptr_d = wr_ptr_q ^ do_wr;
        rd_ptr_d = rd_ptr_q ^ free_rd;
    end

    // Row counter follows the sensor: every NEW_ROW advances it, dropped or not;
    // FRAME_FINISHED wins and restarts at 0 after the current row has been tagged.
    always_comb begin
        row_cnt_d = row_cnt_q;
        if (FRAME_FINISHED) begin
            row_cnt_d = '0;
        end else if (NEW_ROW) begin
            row_cnt_d = (row_cnt_q == LAST_ROW) ? '0 : row_cnt_q + ROW_W'(1);
        end
    end

    // FSM: stream whenever a row is buffered at the end of the cycle, else idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (occ_d != 2'd0) state_d = ST_STREAM;
            ST_STREAM: if (occ_d == 2'd0) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Column stepping: advance on each transfer, wrap to 0 when the row is finished.
    always_comb begin
        out_col_d = out_col_q;
        if (free_rd) begin
            out_col_d = '0;
        end else if (xfer) begin
            out_col_d = out_col_q + COL_W'(1);
        end
    end

    // Output pixel is looked up from next-cycle buffer state, so a freshly written row
    // (or the other entry after a row completes) appears without an extra cycle.
    always_comb begin
        sel_row    = buf_data_d[rd_ptr_d];
        out_data_d = '0;
        out_row_d  = '0;
        if (state_d == ST_STREAM) begin
            for (int c = 0; c < PIXEL_ARRAY_WIDTH; c++) begin
                if (out_col_d == COL_W'(c)) begin
                    out_data_d = sel_row[c*PIXEL_BITS +: PIXEL_BITS];
                end
            end
            out_row_d = buf_row_d[rd_ptr_d];
        end
        out_last_d = (state_d == ST_STREAM) && (out_col_d == LAST_COL) && (out_row_d == LAST_ROW);
        overrun_d  = overrun_q || drop;
    end

    // State registers; reset empties both entries and clears every output at once.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int e = 0; e < 2; e++) begin
                buf_data_q[e] <= '0;
                buf_row_q[e]  <= '0;
            end
            occ_q      <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            row_cnt_q  <= '0;
            state_q    <= ST_IDLE;
            out_data_q <= '0;
            out_row_q  <= '0;
            out_col_q  <= '0;
            out_last_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            for (int e = 0; e < 2; e++) begin
                buf_data_q[e] <= buf_data_d[e];
                buf_row_q[e]  <= buf_row_d[e];
            end
            occ_q      <= occ_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            row_cnt_q  <= row_cnt_d;
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_row_q  <= out_row_d;
            out_col_q  <= out_col_d;
            out_last_q <= out_last_d;
            overrun_q  <= overrun_d;
        end
    end

    assign OUT_VALID = (state_q == ST_STREAM);
    assign OUT_DATA  = out_data_q;
    assign OUT_ROW   = out_row_q;
    assign OUT_COL   = out_col_q;
    assign OUT_LAST  = out_last_q;
    assign OVERRUN   = overrun_q;

endmodule

// File: tb/tb_pixel_row_reader.sv
// Purpose: self-checking bench for pixel_row_reader (vector table, corner sequences, random vs queue model).
// Latency: outputs compared 1 time unit after each rising edge against the expected post-edge state.
// Backpressure: OUT_READY is driven from the table, the sequences and random draws.
module tb_pixel_row_reader;

    localparam int W  = 2;
    localparam int H  = 2;
    localparam int PB = 8;
    localparam int RW = W * PB;

    logic          CLK;
    logic          RESET_N;
    logic          NEW_ROW;
    logic          FRAME_FINISHED;
    logic [RW-1:0] ROW_DATA;
    logic [PB-1:0] OUT_DATA;
    logic          OUT_VALID;
    logic          OUT_READY;
    logic [0:0]    OUT_ROW;
    logic [0:0]    OUT_COL;
    logic          OUT_LAST;
    logic          OVERRUN;

    int checks = 0;
    int errors = 0;

    pixel_row_reader #(
        .PIXEL_ARRAY_WIDTH (W),
        .PIXEL_ARRAY_HEIGHT(H),
        .PIXEL_BITS        (PB)
    ) dut (
        .CLK           (CLK),
        .RESET_N       (RESET_N),
        .NEW_ROW       (NEW_ROW),
        .FRAME_FINISHED(FRAME_FINISHED),
        .ROW_DATA      (ROW_DATA),
        .OUT_DATA      (OUT_DATA),
        .OUT_VALID     (OUT_VALID),
        .OUT_READY     (OUT_READY),
        .OUT_ROW       (OUT_ROW),
        .OUT_COL       (OUT_COL),
        .OUT_LAST      (OUT_LAST),
        .OVERRUN       (OVERRUN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- reference model: a queue of whole rows ----------------
    typedef struct {
        logic [RW-1:0] data;
        int            row;
    } mrow_t;

    mrow_t m_q[$];
    int    m_col;
    int    m_rowcnt;
    bit    m_overrun;

    task automatic model_reset();
        m_q.delete();
        m_col     = 0;
        m_rowcnt  = 0;
        m_overrun = 1'b0;
    endtask

    // One clock edge: the presented pixel (if any) is consumed when ready, then a new
    // row is accepted if fewer than two rows remain queued.
    task automatic model_step(input bit nr, input bit ff, input logic [RW-1:0] d, input bit rdy);
        mrow_t r;
        if (m_q.size() > 0 && rdy) begin
            if (m_col == W - 1) begin
                void'(m_q.pop_front());
                m_col = 0;
            end else begin
                m_col++;
            end
        end
        if (nr) begin
            if (m_q.size() < 2) begin
                r.data = d;
                r.row  = m_rowcnt;
                m_q.push_back(r);
            end else begin
                m_overrun = 1'b1;
            end
        end
        if (ff)      m_rowcnt = 0;
        else if (nr) m_rowcnt = (m_rowcnt + 1) % H;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model(input string tag);
        bit      ev;
        longint  ed;
        longint  er;
        ev = (m_q.size() > 0);
        check({tag, "_valid"}, OUT_VALID, ev);
        check({tag, "_overrun"}, OVERRUN, m_overrun);
        if (ev) begin
            ed = longint'((m_q[0].data >> (m_col * PB)) & ((1 << PB) - 1));
            er = m_q[0].row;
            check({tag, "_data"}, OUT_DATA, ed);
            check({tag, "_row"}, OUT_ROW, er);
            check({tag, "_col"}, OUT_COL, m_col);
            check({tag, "_last"}, OUT_LAST, (m_col == W - 1) && (er == H - 1));
        end else begin
            check({tag, "_last"}, OUT_LAST, 0);
        end
    endtask

    // Drive one cycle of inputs, clock, advance model, compare.
    task automatic step(input string tag, input bit nr, input bit ff, input logic [RW-1:0] d, input bit rdy);
        NEW_ROW        = nr;
        FRAME_FINISHED = ff;
        ROW_DATA       = d;
        OUT_READY      = rdy;
        @(posedge CLK);
        model_step(nr, ff, d, rdy);
        #1;
        compare_model(tag);
    endtask

    task automatic do_reset();
        NEW_ROW        = 1'b0;
        FRAME_FINISHED = 1'b0;
        OUT_READY      = 1'b0;
        ROW_DATA       = '0;
        RESET_N        = 1'b0;
        model_reset();
        @(negedge CLK);
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit            nr;
        bit            ff;
        logic [RW-1:0] dat;
        bit            rdy;
        bit            ev;
        int            ed;
        int            er;
        int            ec;
        bit            el;
        bit            eo;
    } vec_t;

    vec_t vecs[14];

    initial begin
        logic [RW-1:0] rd;
        bit nr;
        bit ff;
        bit rdy;

        // basic two-row stream, then five cycles of backpressure
        vecs[0]  = '{1'b1, 1'b0, 16'hB2A1, 1'b1, 1'b1, 'hA1, 0, 0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 'hB2, 0, 1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0,    0, 0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 16'hD4C3, 1'b1, 1'b1, 'hC3, 1, 0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 'hD4, 1, 1, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0,    0, 0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 16'h2211, 1'b0, 1'b1, 'h11, 0, 0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b1, 'h11, 0, 0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 16'h5A5A, 1'b0, 1'b1, 'h11, 0, 0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 'h11, 0, 0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 16'h1234, 1'b0, 1'b1, 'h11, 0, 0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 'h11, 0, 0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 'h22, 0, 1, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0,    0, 0, 1'b0, 1'b0};

        NEW_ROW        = 1'b0;
        FRAME_FINISHED = 1'b0;
        ROW_DATA       = '0;
        OUT_READY      = 1'b0;
        RESET_N        = 1'b0;
        model_reset();
        #7;
        check("rst_valid", OUT_VALID, 0);
        check("rst_data", OUT_DATA, 0);
        check("rst_row", OUT_ROW, 0);
        check("rst_col", OUT_COL, 0);
        check("rst_last", OUT_LAST, 0);
        check("rst_overrun", OVERRUN, 0);
        @(negedge CLK);
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;

        for (int i = 0; i < 14; i++) begin
            NEW_ROW        = vecs[i].nr;
            FRAME_FINISHED = vecs[i].ff;
            ROW_DATA       = vecs[i].dat;
            OUT_READY      = vecs[i].rdy;
            @(posedge CLK);
            model_step(vecs[i].nr, vecs[i].ff, vecs[i].dat, vecs[i].rdy);
            #1;
            check($sformatf("vec%0d_valid", i), OUT_VALID, vecs[i].ev);
            check($sformatf("vec%0d_last", i), OUT_LAST, vecs[i].el);
            check($sformatf("vec%0d_overrun", i), OVERRUN, vecs[i].eo);
            if (vecs[i].ev) begin
                check($sformatf("vec%0d_data", i), OUT_DATA, vecs[i].ed);
                check($sformatf("vec%0d_row", i), OUT_ROW, vecs[i].er);
                check($sformatf("vec%0d_col", i), OUT_COL, vecs[i].ec);
            end
        end

        // ---- async reset mid-stream clears outputs within the cycle, drops buffered rows
        step("t1_fill", 1'b1, 1'b0, 16'h9988, 1'b0);
        step("t1_fill", 1'b1, 1'b0, 16'h7766, 1'b0);
        #2;
        RESET_N = 1'b0;
        #1;
        check("t1_valid", OUT_VALID, 0);
        check("t1_data", OUT_DATA, 0);
        check("t1_row", OUT_ROW, 0);
        check("t1_col", OUT_COL, 0);
        check("t1_last", OUT_LAST, 0);
        check("t1_overrun", OVERRUN, 0);
        model_reset();
        #2;
        RESET_N = 1'b1;
        step("t1_empty", 1'b0, 1'b0, 16'h0000, 1'b1);
        step("t1_empty", 1'b0, 1'b0, 16'h0000, 1'b1);
        check("t1_still_empty", OUT_VALID, 0);

        // ---- overrun: third row dropped, then back-to-back drain without bubble
        do_reset();
        step("t4", 1'b1, 1'b0, 16'h2010, 1'b0);
        step("t4", 1'b1, 1'b0, 16'h4030, 1'b0);
        check("t4_no_overrun_yet", OVERRUN, 0);
        step("t4", 1'b1, 1'b0, 16'h6050, 1'b0);
        check("t4_overrun", OVERRUN, 1);
        check("t4_hold_data", OUT_DATA, 'h10);
        step("t4", 1'b0, 1'b0, 16'h0000, 1'b1);
        step("t4", 1'b0, 1'b0, 16'h0000, 1'b1);
        check("t4_nobubble_valid", OUT_VALID, 1);
        check("t4_nobubble_row", OUT_ROW, 1);
        check("t4_nobubble_data", OUT_DATA, 'h30);
        step("t4", 1'b0, 1'b0, 16'h0000, 1'b1);
        check("t4_last", OUT_LAST, 1);
        step("t4", 1'b0, 1'b0, 16'h0000, 1'b1);
        check("t4_drained", OUT_VALID, 0);
        check("t4_sticky", OVERRUN, 1);

        // ---- free-and-fill: row arrives on the edge where the full buffer frees an entry
        do_reset();
        step("t5", 1'b1, 1'b0, 16'hA2A1, 1'b0);
        step("t5", 1'b1, 1'b0, 16'hB2B1, 1'b0);
        step("t5", 1'b0, 1'b0, 16'h0000, 1'b1);
        step("t5", 1'b1, 1'b0, 16'hC2C1, 1'b1);
        check("t5_overrun", OVERRUN, 0);
        check("t5_next_row", OUT_DATA, 'hB1);
        step("t5", 1'b0, 1'b0, 16'h0000, 1'b1);
        step("t5", 1'b0, 1'b0, 16'h0000, 1'b1);
        check("t5_captured_data", OUT_DATA, 'hC1);
        check("t5_captured_row", OUT_ROW, 0);
        step("t5", 1'b0, 1'b0, 16'h0000, 1'b1);
        step("t5", 1'b0, 1'b0, 16'h0000, 1'b1);

        // ---- frame restart of the row counter
        do_reset();
        step("t6", 1'b1, 1'b0, 16'h0102, 1'b1);
        step("t6", 1'b0, 1'b0, 16'h0000, 1'b1);
        step("t6", 1'b0, 1'b0, 16'h0000, 1'b1);
        step("t6", 1'b1, 1'b1, 16'h0304, 1'b1);
        check("t6_tag_pre", OUT_ROW, 1);
        step("t6", 1'b0, 1'b0, 16'h0000, 1'b1);
        step("t6", 1'b1, 1'b1, 16'h0506, 1'b1);
        check("t6_tag_after_ff", OUT_ROW, 0);
        step("t6", 1'b0, 1'b0, 16'h0000, 1'b1);
        step("t6", 1'b1, 1'b0, 16'h0708, 1'b1);
        check("t6_tag_ff_with_nr_at0", OUT_ROW, 0);
        step("t6", 1'b0, 1'b0, 16'h0000, 1'b1);
        step("t6", 1'b0, 1'b1, 16'h0000, 1'b1);
        step("t6", 1'b1, 1'b0, 16'h090A, 1'b1);
        check("t6_tag_ff_alone", OUT_ROW, 0);
        step("t6", 1'b0, 1'b0, 16'h0000, 1'b1);
        step("t6", 1'b0, 1'b0, 16'h0000, 1'b1);

        // ---- randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            nr  = ($urandom_range(0, 99) < 35);
            ff  = ($urandom_range(0, 99) < 6);
            rdy = (i < 1500) ? ($urandom_range(0, 99) < 55) : ($urandom_range(0, 99) < 90);
            rd  = RW'($urandom);
            step("rnd", nr, ff, rd, rdy);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
